// File: rtl/loopback_inc_bfm_mc.sv
// Multi-channel loopback "inc" engine: per-channel request FIFOs, a
// round-robin arbiter feeding one shared LATENCY-stage arithmetic pipe,
// and per-channel response FIFOs guarded by credit (inflight) counters.

// Simple circular FIFO; the caller guarantees no push when full and no pop
// when empty.
module loopback_inc_bfm_mc_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic [W-1:0]             din_i,
  input  logic                     pop_i,
  output logic [W-1:0]             dout_o,
  output logic [$clog2(DEPTH):0]   cnt_o,
  output logic [$clog2(DEPTH):0]   cnt_d_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Occupancy next-state; simultaneous push and pop leave it unchanged.
  always_comb begin
    cnt_d = cnt_q;
    if (push_i && !pop_i)      cnt_d = cnt_q + CW'(1);
    else if (!push_i && pop_i) cnt_d = cnt_q - CW'(1);
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap freely.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + AW'(1);
      if (pop_i)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: contents are only observed behind cnt_q.
  always_ff @(posedge clock) begin
    if (push_i) mem_q[wr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_q];
  assign cnt_o   = cnt_q;
  assign cnt_d_o = cnt_d;
endmodule

module loopback_inc_bfm_mc #(
  parameter int WIDTH      = 32,
  parameter int N_CHANNELS = 2,
  parameter int DEPTH      = 4,
  parameter int LATENCY    = 1,
  parameter int SATURATE   = 0
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [N_CHANNELS-1:0]         req_valid,
  output logic [N_CHANNELS-1:0]         req_ready,
  input  logic [2*N_CHANNELS-1:0]       req_op,
  input  logic [WIDTH*N_CHANNELS-1:0]   req_data,
  output logic [N_CHANNELS-1:0]         rsp_valid,
  input  logic [N_CHANNELS-1:0]         rsp_ready,
  output logic [WIDTH*N_CHANNELS-1:0]   rsp_data,
  output logic [N_CHANNELS-1:0]         rsp_ovf,
  output logic                          busy,
  output logic [31:0]                   txn_count
);
  localparam int CHW = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam logic [WIDTH-1:0] ALL1 = '1;
  localparam logic [WIDTH-1:0] MNEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MPOS = ~MNEG;

  typedef struct packed {
    logic [1:0]       op;
    logic [WIDTH-1:0] data;
  } req_t;

  typedef struct packed {
    logic             ovf;
    logic [WIDTH-1:0] data;
  } rsp_t;

  req_t [N_CHANNELS-1:0]         req_head;
  rsp_t [N_CHANNELS-1:0]         rsp_head;
  logic [N_CHANNELS-1:0][CW-1:0] reqc, reqc_d, rspc, rspc_d;
  logic [N_CHANNELS-1:0]         eligible, issue, rsp_push, rsp_pop;

  logic            gnt_vld;
  logic [CHW-1:0]  gnt_ch, rr_q, rr_d, idx;
  req_t            issue_req;

  logic [LATENCY:1] vld_pipe_q, vld_pipe_d;
  rsp_t             pipe_rsp_q [LATENCY:1];
  logic [CHW-1:0]   pipe_ch_q  [LATENCY:1];

  logic        busy_q, busy_d;
  logic [31:0] txn_q, txn_d;

  // Result and overflow flag for one request; clamps when SATURATE is set.
  function automatic rsp_t calc(input req_t r);
    rsp_t o;
    o.ovf  = 1'b0;
    o.data = r.data;
    case (r.op)
      2'b00: begin
        o.ovf  = (r.data == ALL1);
        o.data = (o.ovf && SATURATE != 0) ? ALL1 : r.data + WIDTH'(1);
      end
      2'b01: begin
        o.ovf  = (r.data == '0);
        o.data = (o.ovf && SATURATE != 0) ? '0 : r.data - WIDTH'(1);
      end
      2'b10: begin
        o.ovf  = 1'b0;
        o.data = r.data;
      end
      2'b11: begin
        o.ovf  = (r.data == MNEG);
        o.data = (o.ovf && SATURATE != 0) ? MPOS : ~r.data + WIDTH'(1);
      end
    endcase
    return o;
  endfunction

  for (genvar c = 0; c < N_CHANNELS; c++) begin : g_ch
    logic [CW-1:0] infl_q;

    assign req_ready[c] = (reqc[c] != CW'(DEPTH));
    assign rsp_valid[c] = (rspc[c] != '0);
    assign rsp_pop[c]   = rsp_valid[c] & rsp_ready[c];
    // Credit check keeps pipeline + response FIFO within DEPTH entries.
    assign eligible[c]  = (reqc[c] != '0) && (infl_q < CW'(DEPTH));
    assign issue[c]     = gnt_vld && (gnt_ch == CHW'(c));
    assign rsp_push[c]  = vld_pipe_q[LATENCY] && (pipe_ch_q[LATENCY] == CHW'(c));

    loopback_inc_bfm_mc_fifo #(.W($bits(req_t)), .DEPTH(DEPTH)) u_req (
      .clock   (clock),
      .reset_n (reset_n),
      .push_i  (req_valid[c] & req_ready[c]),
      .din_i   ({req_op[2*c +: 2], req_data[c*WIDTH +: WIDTH]}),
      .pop_i   (issue[c]),
      .dout_o  (req_head[c]),
      .cnt_o   (reqc[c]),
      .cnt_d_o (reqc_d[c])
    );

    loopback_inc_bfm_mc_fifo #(.W($bits(rsp_t)), .DEPTH(DEPTH)) u_rsp (
      .clock   (clock),
      .reset_n (reset_n),
      .push_i  (rsp_push[c]),
      .din_i   (pipe_rsp_q[LATENCY]),
      .pop_i   (rsp_pop[c]),
      .dout_o  (rsp_head[c]),
      .cnt_o   (rspc[c]),
      .cnt_d_o (rspc_d[c])
    );

    // Inflight credits: +1 on issue, -1 on response pop.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)                   infl_q <= '0;
      else if (issue[c] && !rsp_pop[c]) infl_q <= infl_q + CW'(1);
      else if (!issue[c] && rsp_pop[c]) infl_q <= infl_q - CW'(1);
    end

    // Outputs read as zero when no response is pending.
    assign rsp_data[c*WIDTH +: WIDTH] = rsp_valid[c] ? rsp_head[c].data : '0;
    assign rsp_ovf[c]                 = rsp_valid[c] & rsp_head[c].ovf;
  end

  // Round-robin search from rr_q upward, first eligible channel wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_ch  = '0;
    idx     = '0;
    for (int i = 0; i < N_CHANNELS; i++) begin
      idx = CHW'((int'(rr_q) + i) % N_CHANNELS);
      if (!gnt_vld && eligible[idx]) begin
        gnt_vld = 1'b1;
        gnt_ch  = idx;
      end
    end
    rr_d = rr_q;
    if (gnt_vld) rr_d = (gnt_ch == CHW'(N_CHANNELS-1)) ? '0 : gnt_ch + CHW'(1);
  end

  assign issue_req = req_head[gnt_ch];

  // Pipe valid shift, busy and delivered-transaction next state.
  always_comb begin
    vld_pipe_d    = '0;
    vld_pipe_d[1] = gnt_vld;
    for (int s = 2; s <= LATENCY; s++) vld_pipe_d[s] = vld_pipe_q[s-1];
    busy_d = |vld_pipe_d;
    txn_d  = txn_q;
    for (int c = 0; c < N_CHANNELS; c++) begin
      if (reqc_d[c] != '0 || rspc_d[c] != '0) busy_d = 1'b1;
      if (rsp_pop[c]) txn_d = txn_d + 32'd1;
    end
  end

  // Control state: pipe valids, arbiter pointer, busy, transaction count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe_q <= '0;
      rr_q       <= '0;
      busy_q     <= 1'b0;
      txn_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      rr_q       <= rr_d;
      busy_q     <= busy_d;
      txn_q      <= txn_d;
    end
  end

  // Pipe payload; qualified by vld_pipe_q so it carries no reset.
  always_ff @(posedge clock) begin
    pipe_rsp_q[1] <= calc(issue_req);
    pipe_ch_q[1]  <= gnt_ch;
    for (int s = 2; s <= LATENCY; s++) begin
      pipe_rsp_q[s] <= pipe_rsp_q[s-1];
      pipe_ch_q[s]  <= pipe_ch_q[s-1];
    end
  end

  assign busy      = busy_q;
  assign txn_count = txn_q;
endmodule

// File: doc/loopback_inc_bfm_mc.md
Name: loopback_inc_bfm_mc

Overview:
Multi-channel, parametrised successor of the single-method loopback "inc" BFM core. N independent request channels carry an op and an operand. Each channel buffers its requests in a FIFO. A round-robin arbiter issues requests into one shared LATENCY-stage arithmetic pipeline, and results return on per-channel response ports with back-pressure. The block sits under the generated BFM core as the HDL-side engine for loopback RPC smoke/stress tests.

Parameters:
WIDTH, 32, operand/result width in bits (>=2).
N_CHANNELS, 2, number of request/response channels (1..8).
DEPTH, 4, per-channel request FIFO and response FIFO depth (power of 2, >=2).
LATENCY, 1, arithmetic pipeline stages (1..4).
SATURATE, 0, 1 = clamp on wrap instead of modulo.

Ports:
clock  in  1  sole clock, rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  N_CHANNELS  per-channel request valid
req_ready  out  N_CHANNELS  per-channel request ready (= request FIFO not full)
req_op  in  2*N_CHANNELS  per-channel op: 00 inc, 01 dec, 10 echo, 11 negate
req_data  in  WIDTH*N_CHANNELS  per-channel operand, channel c at [c*WIDTH +: WIDTH]
rsp_valid  out  N_CHANNELS  response FIFO not empty
rsp_ready  in  N_CHANNELS  per-channel response accept
rsp_data  out  WIDTH*N_CHANNELS  head-of-response-FIFO result
rsp_ovf  out  N_CHANNELS  head-of-response-FIFO wrap/saturate flag
busy  out  1  any FIFO non-empty or pipeline stage valid
txn_count  out  32  total responses delivered (wraps at 2^32)

Behaviour:
- Reset (async assert, sync release): all FIFOs empty, pipeline valids cleared, credits cleared, RR pointer = 0, txn_count = 0.
- Reset output values: req_ready = all 1, rsp_valid = 0, rsp_data = 0, rsp_ovf = 0, busy = 0, txn_count = 0.
- Reset mid-operation discards all buffered and in-flight work. No rsp_valid may appear after release for pre-reset requests.
- Request accept: req_valid[c] & req_ready[c] at a rising edge pushes {op, data}.
- No bypass: a full FIFO deasserts req_ready even if the FIFO is issuing that same cycle.
- Credits: per channel, inflight[c] = entries in pipeline + entries in response FIFO. Channel c is eligible when its request FIFO is non-empty and inflight[c] < DEPTH. This guarantees the response FIFO never overflows.
- Arbiter: at most one issue per cycle.
  - Search starts at RR pointer, ascending, wrapping.
  - Grant goes to the first eligible channel; pointer then becomes grant+1 mod N_CHANNELS.
  - Pointer is unchanged when nothing is granted.
- Arithmetic, modulo 2^WIDTH:
  - inc: data+1; ovf=1 iff data = all-ones.
  - dec: data-1; ovf=1 iff data = 0.
  - echo: data; ovf=0.
  - negate: two's complement; ovf=1 iff data = 100..0 (most negative value).
- SATURATE=1:
  - inc overflow yields all-ones; dec underflow yields 0.
  - negate of the most negative value yields 011..1.
  - ovf still flags the clamp.
- Pipeline: a request issued at edge k writes the channel's response FIFO at edge k+LATENCY.
- Minimum latency on an idle block: accept at edge t, rsp_valid[c] high after edge t+1+LATENCY.
- Ordering: per-channel responses are strictly FIFO. No ordering is guaranteed across channels.
- Response handshake: rsp_valid[c] & rsp_ready[c] pops the head and decrements inflight[c]. Data and ovf are stable while valid && !ready.
- Same-cycle pop and pipeline write on the same response FIFO both take effect; the count is unchanged.
- txn_count increments by the number of channels popping that cycle (0..N_CHANNELS).
- busy is registered from next-state; it falls the cycle after the last pop.

Test Plan:
- Single inc: N=2, WIDTH=32, LATENCY=1; ch0 sends op=00, data=41 -> rsp_data[0]=42, rsp_ovf=0, rsp_valid after 2 edges, txn_count=1.
- Wrap: ch1 inc 0xFFFFFFFF -> 0, ovf=1; dec 0 -> 0xFFFFFFFF, ovf=1; SATURATE=1 rerun -> 0xFFFFFFFF/ovf=1 and 0/ovf=1; negate 0x80000000 -> 0x80000000 (SAT=0) / 0x7FFFFFFF (SAT=1), ovf=1.
- Fairness: both channels push 4 requests back-to-back, rsp_ready=1 -> issue order ch0,ch1,ch0,ch1..., each channel's results in push order, txn_count=8.
- Back-pressure: DEPTH=4, rsp_ready[0]=0, ch0 pushes 10 -> exactly 4 responses held, request FIFO fills, req_ready[0]=0; ch1 traffic unaffected; releasing rsp_ready drains all 10 in order.
- Reset mid-flight: reset_n low with 3 requests queued and 1 in pipeline -> all outputs at reset values; no rsp_valid for 10 cycles after release; txn_count=0.
- Latency sweep: LATENCY=1..4, echo 0x1234 on idle block -> rsp_valid exactly LATENCY+1 edges after accept.
